// File: rtl/regfile_reader.sv
// regfile_reader: sweeps a contiguous, possibly wrapping range of RegFile
// addresses through one read port and streams (address, value) pairs out
// over a valid/ready handshake.
//
// Optional build macro: REGREAD_CHECKSUM_EN adds the Checksum output, a
// rotate-xor signature over every word accepted during a sweep.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for Start; ReadReg holds the last swept address
// READ  | ReadReg = Addr; word and address are registered at the edge
// HOLD  | word presented on OutValid; waits for OutReady
// DONE  | final word accepted; Done pulses for this single cycle
module regfile_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] ReadReg,
    input  logic [DATA_W-1:0] ReadData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [DATA_W-1:0] OutData,
    output logic              Busy,
    output logic              Done
`ifdef REGREAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] endReg;
    logic              handshake;

    assign handshake = OutValid && OutReady;
    assign ReadReg   = addr;
    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection; Start is only looked at in IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (Start) nextState = READ;
            READ: nextState = HOLD;
            HOLD: begin
                if (handshake) begin
                    nextState = (addr == endReg) ? DONE : READ;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Address walk and output word register; the word is a snapshot taken
    // at the READ edge, so later RegFile writes never disturb a held word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            addr     <= '0;
            endReg   <= '0;
            OutValid <= 1'b0;
            OutAddr  <= '0;
            OutData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        addr   <= FirstReg;
                        endReg <= LastReg;
                    end
                end
                READ: begin
                    OutData  <= ReadData;
                    OutAddr  <= addr;
                    OutValid <= 1'b1;
                end
                HOLD: begin
                    if (handshake) begin
                        OutValid <= 1'b0;
                        if (addr != endReg) begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REGREAD_CHECKSUM_EN
    // Rotate-left-and-xor signature of accepted words; cleared on a new sweep.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Checksum <= '0;
        end else if (state == IDLE && Start) begin
            Checksum <= '0;
        end else if (state == HOLD && handshake) begin
            Checksum <= {Checksum[DATA_W-2:0], Checksum[DATA_W-1]} ^ OutData;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Testbench for regfile_reader: a behavioural RegFile array feeds ReadData,
// and expected word streams are built from the address range rule.
module tb_regfile_reader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [4:0]  FirstReg;
    logic [4:0]  LastReg;
    logic [4:0]  ReadReg;
    logic [31:0] ReadData;
    logic        OutValid;
    logic        OutReady;
    logic [4:0]  OutAddr;
    logic [31:0] OutData;
    logic        Busy;
    logic        Done;
`ifdef REGREAD_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;

    assign ReadData = rf[ReadReg];

    always #5 Clk = ~Clk;

    regfile_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg),
        .ReadReg(ReadReg), .ReadData(ReadData), .OutValid(OutValid), .OutReady(OutReady),
        .OutAddr(OutAddr), .OutData(OutData), .Busy(Busy), .Done(Done)
`ifdef REGREAD_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    endtask

    // Runs one sweep and checks every accepted word against the expected
    // address order, plus stability, Done timing and the checksum rule.
    task automatic runSweep(input int first, input int last, input bit alwaysReady,
                            input bit pokeStart);
        int          expAddr[$];
        logic [31:0] expData[$];
        logic [31:0] expCs;
        int          a;
        int          k;
        int          nWords;
        bit          gotDone;
        bit          prevValid;
        bit          prevHs;
        logic [4:0]  prevAddr;
        logic [31:0] prevData;
        a = first;
        for (int i = 0; i < 32; i++) begin
            expAddr.push_back(a);
            expData.push_back(rf[a]);
            if (a == last) break;
            a = (a + 1) % 32;
        end
        nWords = expAddr.size();
        expCs = 32'h0;
        Start = 1'b1; FirstReg = first[4:0]; LastReg = last[4:0];
        cyc();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || OutValid !== 1'b0)
            begin errors++; $display("FAIL start_latency: Busy=%b OutValid=%b, required 1 0", Busy, OutValid); end
        k = 0; gotDone = 0; prevValid = 0; prevHs = 0; prevAddr = '0; prevData = '0;
        while (k < 3000) begin
            if (pokeStart) begin
                Start = (k == 3);
                FirstReg = 5'($urandom); LastReg = 5'($urandom);
            end
            OutReady = alwaysReady ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (prevValid && !prevHs) begin
                checks++;
                if (OutValid !== 1'b1 || OutAddr !== prevAddr || OutData !== prevData)
                    begin errors++; $display("FAIL hold_stable: valid=%b addr=%0d data=%h, required 1 %0d %h", OutValid, OutAddr, OutData, prevAddr, prevData); end
            end
            if (OutValid && OutReady) begin
                checks++;
                if (expAddr.size() == 0) begin
                    errors++; $display("FAIL extra_word: addr=%0d data=%h, required no word", OutAddr, OutData);
                end else begin
                    if (OutAddr !== expAddr[0][4:0] || OutData !== expData[0])
                        begin errors++; $display("FAIL word: addr=%0d data=%h, required %0d %h", OutAddr, OutData, expAddr[0], expData[0]); end
                    expCs = ((expCs << 1) | (expCs >> 31)) ^ expData[0];
                    void'(expAddr.pop_front());
                    void'(expData.pop_front());
                end
            end
            if (Done === 1'b1) begin gotDone = 1; break; end
            checks++;
            if (Busy !== 1'b1)
                begin errors++; $display("FAIL busy_during: Busy=%b, required 1", Busy); end
            prevValid = OutValid; prevHs = OutValid && OutReady;
            prevAddr = OutAddr; prevData = OutData;
            cyc();
            k++;
        end
        Start = 1'b0;
        checks++;
        if (!gotDone) begin errors++; $display("FAIL done_timeout: no Done after %0d cycles, required Done", k); end
        checks++;
        if (expAddr.size() != 0)
            begin errors++; $display("FAIL word_count: missing %0d of %0d words, required 0 missing", expAddr.size(), nWords); end
        if (alwaysReady) begin
            checks++;
            if (k != 2 * nWords)
                begin errors++; $display("FAIL done_timing: Done %0d cycles after Start, required %0d", k, 2 * nWords); end
        end
`ifdef REGREAD_CHECKSUM_EN
        checks++;
        if (Checksum !== expCs)
            begin errors++; $display("FAIL checksum: got %h, required %h", Checksum, expCs); end
`endif
        OutReady = 1'b0;
        if (pokeStart) begin
            Start = 1'b1; FirstReg = 5'($urandom); LastReg = 5'($urandom);
        end
        cyc();
        Start = 1'b0;
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0)
            begin errors++; $display("FAIL after_done: Done=%b Busy=%b, required 0 0", Done, Busy); end
        cyc();
        checks++;
        if (Busy !== 1'b0)
            begin errors++; $display("FAIL start_in_done: Busy=%b, required 0", Busy); end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; OutReady = 1'b0; FirstReg = '0; LastReg = '0;
        cyc(); cyc();
        checks++;
        if (OutValid !== 1'b0 || OutAddr !== 5'd0 || OutData !== 32'd0 || Busy !== 1'b0 ||
            Done !== 1'b0 || ReadReg !== 5'd0)
            begin errors++; $display("FAIL reset_values: v=%b a=%0d d=%h busy=%b done=%b rr=%0d, required all 0", OutValid, OutAddr, OutData, Busy, Done, ReadReg); end
`ifdef REGREAD_CHECKSUM_EN
        checks++;
        if (Checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum: got %h, required 0", Checksum); end
`endif
        Rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        preload();
        runSweep(2, 5, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        runSweep(30, 1, 1'b1, 1'b0);
        runSweep(7, 7, 1'b1, 1'b0);
        runSweep(0, 31, 1'b1, 1'b0);
    endtask

    task automatic test_snapshot();
        int k;
        preload();
        OutReady = 1'b0;
        Start = 1'b1; FirstReg = 5'd2; LastReg = 5'd5;
        cyc(); Start = 1'b0;
        cyc();
        rf[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (OutValid !== 1'b1 || OutAddr !== 5'd2 || OutData !== 32'h1000_0002 || ReadReg !== 5'd2)
                begin errors++; $display("FAIL snapshot: v=%b a=%0d d=%h rr=%0d, required 1 2 10000002 2", OutValid, OutAddr, OutData, ReadReg); end
            cyc();
        end
        OutReady = 1'b1;
        k = 0;
        while (Done !== 1'b1 && k < 50) begin cyc(); k++; end
        checks++;
        if (Done !== 1'b1) begin errors++; $display("FAIL snapshot_done: Done=%b, required 1", Done); end
        OutReady = 1'b0;
        cyc();
        preload();
    endtask

    task automatic test_reset_mid();
        OutReady = 1'b0;
        Start = 1'b1; FirstReg = 5'd2; LastReg = 5'd5;
        cyc(); Start = 1'b0;
        cyc();
        OutReady = 1'b1;
        cyc();
        OutReady = 1'b0;
        cyc();
        checks++;
        if (OutValid !== 1'b1 || OutAddr !== 5'd3 || OutData !== 32'h1000_0003)
            begin errors++; $display("FAIL mid_second_word: v=%b a=%0d d=%h, required 1 3 10000003", OutValid, OutAddr, OutData); end
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || OutAddr !== 5'd0 || OutData !== 32'd0)
            begin errors++; $display("FAIL mid_reset: v=%b busy=%b done=%b a=%0d d=%h, required 0 0 0 0 0", OutValid, Busy, Done, OutAddr, OutData); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0)
                begin errors++; $display("FAIL mid_reset_quiet: Done=%b Busy=%b, required 0 0", Done, Busy); end
        end
        runSweep(2, 5, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        runSweep(2, 5, 1'b1, 1'b1);
        runSweep(28, 3, 1'b1, 1'b1);
    endtask

    task automatic test_checksum();
        preload();
        rf[2] = 32'h0000_0001;
        rf[3] = 32'h8000_0000;
        runSweep(2, 3, 1'b1, 1'b0);
`ifdef REGREAD_CHECKSUM_EN
        checks++;
        if (Checksum !== 32'h8000_0002)
            begin errors++; $display("FAIL checksum_fixed: got %h, required 80000002", Checksum); end
`endif
        preload();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            runSweep($urandom_range(0, 31), $urandom_range(0, 31), 1'b0, n[0]);
        end
        preload();
    endtask

    initial begin
        preload();
        test_reset();
        test_basic();
        test_wrap();
        test_snapshot();
        test_reset_mid();
        test_start_ignored();
        test_checksum();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential read-back engine for the single-cycle MIPS register file. On a start pulse it walks a contiguous, possibly wrapping range of register addresses through one RegFile read port and streams each (address, value) pair out over a valid/ready handshake. It is the reading counterpart to the write-side stimulus sequencing, and is used for register dumps, self-checking regression and debug.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- Start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- FirstReg  in  ADDR_W  first address of sweep, captured on accepted Start
- LastReg  in  ADDR_W  last address of sweep, inclusive, captured on accepted Start
- ReadReg  out  ADDR_W  address driven to RegFile read port
- ReadData  in  DATA_W  combinational RegFile read data for ReadReg
- OutValid  out  1  OutAddr/OutData hold a valid word
- OutReady  in  1  consumer accepts word when OutValid && OutReady
- OutAddr  out  ADDR_W  address of streamed word
- OutData  out  DATA_W  value of streamed word
- Busy  out  1  high in any state except IDLE
- Done  out  1  one-cycle pulse after final word is accepted
- Checksum  out  DATA_W  present only with REGREAD_CHECKSUM_EN

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: Busy=0, OutValid=0. Start=1 -> capture FirstReg into address counter Addr and LastReg into End; -> READ.
- READ: ReadReg=Addr; at clock edge OutData<=ReadData, OutAddr<=Addr, OutValid<=1; -> HOLD.
- HOLD: OutValid=1, OutAddr/OutData stable. On OutValid&&OutReady: OutValid<=0; if Addr==End -> DONE, else Addr<=Addr+1 (mod 2^ADDR_W) -> READ. Without OutReady, remain in HOLD indefinitely.
- DONE: Done=1 for exactly this cycle; Busy=1; -> IDLE.
- ReadReg equals Addr in every state (holds last value in IDLE).
- Wrap: FirstReg>LastReg sweeps FirstReg..31, 0..LastReg. FirstReg==LastReg streams exactly one word. Range 0..31 streams 32 words; count never exceeds 2^ADDR_W.
- Snapshot semantics: each word reflects RegFile content at its READ cycle edge; later writes to that register are not reflected in held OutData.
- Start asserted while Busy is ignored, including in DONE.
- Rst in any state: -> IDLE next edge, sweep discarded, no Done pulse.

## Timing
- Reset values: ReadReg=0, OutValid=0, OutAddr=0, OutData=0, Busy=0, Done=0, Checksum=0.
- Start at edge n -> Busy=1 after n; OutValid=1 after n+1.
- One word per 2 cycles with OutReady tied high; N-word sweep with OutReady=1: Start edge to Done high = 2N cycles, Done high for 1 cycle, IDLE next cycle. Busy high for 2N+1 cycles.
- Back-to-back sweeps: Start accepted earliest in the IDLE cycle following DONE.
- OutValid never deasserts without a handshake or Rst.

## Configuration
- REGREAD_CHECKSUM_EN defined: Checksum port and register exist. Cleared to 0 on accepted Start; on each handshake Checksum <= {Checksum[DATA_W-2:0],Checksum[DATA_W-1]} ^ OutData. Value is final and stable from the Done cycle until next accepted Start or Rst.
- Not defined: Checksum port, register and logic absent; all other behaviour identical.

## Test plan
- RegFile preloaded r[i]=32'h1000_0000+i; Start, FirstReg=2, LastReg=5, OutReady=1 -> words (2,10000002),(3,10000003),(4,10000004),(5,10000005) on every other cycle; Done 8 cycles after Start edge.
- FirstReg=30, LastReg=1 -> addresses 30,31,0,1 in that order, exactly 4 words, then Done.
- OutReady held low 10 cycles on first word, RegFile r2 rewritten to 32'hDEADBEEF meanwhile -> OutValid stays 1, OutData stays 10000002, r2 not re-read.
- Rst asserted while in HOLD on second word -> next cycle OutValid=0, Busy=0, Done never pulses; new Start then behaves as from reset.
- Start re-pulsed mid-sweep and during DONE -> ignored; word count and Done timing unchanged.
- With REGREAD_CHECKSUM_EN, r2=32'h0000_0001, r3=32'h8000_0000, sweep 2..3 -> Checksum=32'h8000_0002 at Done; with REGREAD_CHECKSUM_EN undefined, bench compiles without Checksum.
